// File: rtl/serial_command_initiator.sv
// Serial memory-command initiator: frames word read/write requests as UART bytes and parses
// the responder's reply. Define SERIAL_CMD_CHECKSUM_EN to add modulo-256 checksum bytes.
module serial_command_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned TIMEOUT_W      = 32
) (
    input  logic        clkIn,
    input  logic        rstIn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_error,
    output logic [7:0]  tx_byte,
    output logic        start_tx,
    input  logic        tx_ready,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic        busy
);

`ifdef SERIAL_CMD_CHECKSUM_EN
    localparam bit CHECKSUM_EN = 1'b1;
`else
    localparam bit CHECKSUM_EN = 1'b0;
`endif

    localparam logic [3:0] WR_FRAME_LEN = CHECKSUM_EN ? 4'd10 : 4'd9;
    localparam logic [3:0] RD_FRAME_LEN = CHECKSUM_EN ? 4'd6 : 4'd5;
    // Expiry is decided one cycle early so DONE lands exactly when the count hits its limit.
    localparam logic [TIMEOUT_W-1:0] TOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 2);

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0] ERR_BAD_ACK  = 2'b10;
    localparam logic [1:0] ERR_CHECKSUM = 2'b11;

    typedef enum logic [2:0] {StIdle, StSend, StTxHold, StWaitResp, StDone} state_e;

    state_e                 state_q, state_d;
    logic                   is_write_q, is_write_d;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [3:0]             tx_cnt_q, tx_cnt_d;
    logic [7:0]             sum_q, sum_d;
    logic [2:0]             rx_cnt_q, rx_cnt_d;
    logic                   rx_pend_q, rx_pend_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic [31:0]            shadow_q, shadow_d;
    logic [TIMEOUT_W-1:0]   tout_q, tout_d;
    logic [31:0]            resp_rdata_q, resp_rdata_d;
    logic [1:0]             resp_error_q, resp_error_d;

    logic [7:0] frame_byte;
    logic [3:0] frame_len;
    logic [7:0] data_sum;
    logic       finish;
    logic [1:0] err;

    assign frame_len = is_write_q ? WR_FRAME_LEN : RD_FRAME_LEN;
    assign data_sum  = shadow_q[31:24] + shadow_q[23:16] + shadow_q[15:8] + shadow_q[7:0];

    always_comb begin
        frame_byte = 8'h00;
        case (tx_cnt_q)
            4'd0:    frame_byte = is_write_q ? 8'h57 : 8'h52;
            4'd1:    frame_byte = addr_q[31:24];
            4'd2:    frame_byte = addr_q[23:16];
            4'd3:    frame_byte = addr_q[15:8];
            4'd4:    frame_byte = addr_q[7:0];
            4'd5:    frame_byte = is_write_q ? wdata_q[31:24] : sum_q;
            4'd6:    frame_byte = wdata_q[23:16];
            4'd7:    frame_byte = wdata_q[15:8];
            4'd8:    frame_byte = wdata_q[7:0];
            4'd9:    frame_byte = sum_q;
            default: frame_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        is_write_d   = is_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        tx_cnt_d     = tx_cnt_q;
        sum_d        = sum_q;
        rx_cnt_d     = rx_cnt_q;
        shadow_d     = shadow_q;
        tout_d       = tout_q;
        resp_rdata_d = resp_rdata_q;
        resp_error_d = resp_error_q;
        finish       = 1'b0;
        err          = ERR_OK;
        // Bytes are only captured while a response is awaited; anything earlier is stale.
        rx_pend_d    = (state_q == StWaitResp) && rx_valid;
        rx_data_d    = rx_valid ? rx_byte : rx_data_q;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    is_write_d = req_write;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    tx_cnt_d   = 4'd0;
                    sum_d      = 8'h00;
                    rx_cnt_d   = 3'd0;
                    shadow_d   = 32'h0;
                    state_d    = StSend;
                end
            end
            StSend: begin
                if (tx_ready) begin
                    tx_cnt_d = tx_cnt_q + 4'd1;
                    sum_d    = sum_q + frame_byte;
                    state_d  = StTxHold;
                end
            end
            StTxHold: begin
                if (tx_cnt_q == frame_len) begin
                    tout_d  = '0;
                    state_d = StWaitResp;
                end else begin
                    state_d = StSend;
                end
            end
            StWaitResp: begin
                tout_d = rx_valid ? '0 : tout_q + TIMEOUT_W'(1);
                if (rx_pend_q) begin
                    rx_cnt_d = rx_cnt_q + 3'd1;
                    if (is_write_q) begin
                        finish = 1'b1;
                        err    = (rx_data_q == 8'h06) ? ERR_OK : ERR_BAD_ACK;
                    end else if (rx_cnt_q < 3'd4) begin
                        shadow_d = {shadow_q[23:0], rx_data_q};
                        if (!CHECKSUM_EN && rx_cnt_q == 3'd3) begin
                            finish = 1'b1;
                        end
                    end else if (CHECKSUM_EN) begin
                        finish = 1'b1;
                        err    = (rx_data_q == data_sum) ? ERR_OK : ERR_CHECKSUM;
                    end
                end
                if (!finish && !rx_valid && tout_q == TOUT_LAST) begin
                    finish = 1'b1;
                    err    = ERR_TIMEOUT;
                end
                if (finish) begin
                    resp_error_d = err;
                    if (!is_write_q) begin
                        resp_rdata_d = shadow_d;
                    end
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            state_q      <= StIdle;
            is_write_q   <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            tx_cnt_q     <= 4'd0;
            sum_q        <= 8'h00;
            rx_cnt_q     <= 3'd0;
            rx_pend_q    <= 1'b0;
            rx_data_q    <= 8'h00;
            shadow_q     <= 32'h0;
            tout_q       <= '0;
            resp_rdata_q <= 32'h0;
            resp_error_q <= ERR_OK;
        end else begin
            state_q      <= state_d;
            is_write_q   <= is_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            tx_cnt_q     <= tx_cnt_d;
            sum_q        <= sum_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_pend_q    <= rx_pend_d;
            rx_data_q    <= rx_data_d;
            shadow_q     <= shadow_d;
            tout_q       <= tout_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
        end
    end

    // start_tx is a direct function of tx_ready so it can never fire while the transmitter is busy.
    assign start_tx   = (state_q == StSend) && tx_ready;
    assign tx_byte    = (state_q == StSend) ? frame_byte : 8'h00;
    assign req_ready  = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign resp_valid = (state_q == StDone);
    assign resp_rdata = resp_rdata_q;
    assign resp_error = resp_error_q;

endmodule

// File: tb/tb_serial_command_initiator.sv
// Self-checking bench for serial_command_initiator: frame/response model plus directed vectors.
// Checksum scenarios run when SERIAL_CMD_CHECKSUM_EN is defined.
module tb_serial_command_initiator;

    localparam int unsigned TOUT = 50;
`ifdef SERIAL_CMD_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        tx_ready = 1'b1;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_valid = 1'b0;
    logic        req_ready, resp_valid, start_tx, busy;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_error;
    logic [7:0]  tx_byte;

    serial_command_initiator #(.TIMEOUT_CYCLES(TOUT), .TIMEOUT_W(32)) dut (
        .clkIn(clk), .rstIn(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .tx_byte(tx_byte), .start_tx(start_tx), .tx_ready(tx_ready),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state
    logic [7:0]  exp_tx [$];
    logic [7:0]  tx_log [$];
    logic [7:0]  rep [8];
    int          n_rep = 0;
    int          frame_len = 0;
    bit          pending = 1'b0;
    bit          active = 1'b0;
    logic [1:0]  exp_err = 2'b00;
    logic [31:0] exp_rdata = 32'h0;
    logic [31:0] last_rdata = 32'h0;
    int          exp_lat = -1;
    int          last_rx_cyc = 0;
    int          resp_cnt = 0;
    int          n0;
    logic [7:0]  lit [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_resp_rdata"}, resp_rdata, 0);
        check({tag, "_resp_error"}, resp_error, 0);
        check({tag, "_tx_byte"}, tx_byte, 0);
        check({tag, "_start_tx"}, start_tx, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // Expected command frame: opcode, big-endian address, data, optional sum byte.
    task automatic build_frame(input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
        logic [7:0] s;
        exp_tx.delete();
        tx_log.delete();
        exp_tx.push_back(wr ? 8'h57 : 8'h52);
        for (int i = 3; i >= 0; i--) exp_tx.push_back(addr[i*8 +: 8]);
        if (wr) for (int i = 3; i >= 0; i--) exp_tx.push_back(wdata[i*8 +: 8]);
        if (CK) begin
            s = 8'h00;
            foreach (exp_tx[i]) s = s + exp_tx[i];
            exp_tx.push_back(s);
        end
        frame_len = exp_tx.size();
    endtask

    // Expected outcome from the reply bytes the responder will send before going silent.
    task automatic model_resp(input bit wr);
        logic [31:0] acc;
        logic [7:0]  s;
        int          k;
        exp_rdata = last_rdata;
        if (wr) begin
            exp_err = (n_rep == 0) ? 2'b01 : ((rep[0] == 8'h06) ? 2'b00 : 2'b10);
        end else begin
            acc = 32'h0;
            k = (n_rep < 4) ? n_rep : 4;
            for (int i = 0; i < k; i++) acc = {acc[23:0], rep[i]};
            exp_rdata = acc;
            s = acc[31:24] + acc[23:16] + acc[15:8] + acc[7:0];
            if (n_rep < (CK ? 5 : 4)) exp_err = 2'b01;
            else if (CK && rep[4] != s) exp_err = 2'b11;
            else exp_err = 2'b00;
        end
    endtask

    // Single compare process, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            active = 1'b0;
        end else begin
            check("busy", busy, active);
            check("req_ready", req_ready, !active);
            if (start_tx) begin
                check("start_tx_while_not_ready", tx_ready, 1);
                tx_log.push_back(tx_byte);
                if (exp_tx.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL tx_extra: got byte %h, expected no transmit", tx_byte);
                end else begin
                    check("tx_byte", tx_byte, exp_tx.pop_front());
                end
            end
            if (resp_valid) begin
                resp_cnt++;
                if (!pending) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL resp_unexpected: got resp_valid, expected none");
                end else begin
                    check("resp_error", resp_error, exp_err);
                    check("resp_rdata", resp_rdata, exp_rdata);
                    if (exp_lat >= 0) check("resp_latency", cyc - last_rx_cyc, exp_lat);
                    last_rdata = exp_rdata;
                    pending = 1'b0;
                end
                active = 1'b0;
            end
            if (req_valid && req_ready) active = 1'b1;
        end
    end

    task automatic issue_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
        bit acc_ok;
        acc_ok = 1'b0;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (req_ready) begin
                acc_ok = 1'b1;
                break;
            end
        end
        check("req_accepted", acc_ok, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Holds tx_ready low for 20 cycles and injects a byte while the DUT is stuck in SEND.
    task automatic stall_seq();
        @(posedge clk);
        #1 tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rx_byte = 8'h15;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
        repeat (17) @(posedge clk);
        #1 tx_ready = 1'b1;
    endtask

    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int gap, input int stall_at, input int lat);
        bit stalled;
        stalled = 1'b0;
        build_frame(wr, addr, wdata);
        model_resp(wr);
        exp_lat = lat;
        pending = 1'b1;
        issue_req(wr, addr, wdata);
        for (int t = 0; t < 400 && tx_log.size() < frame_len; t++) begin
            @(negedge clk);
            if (stall_at > 0 && !stalled && tx_log.size() == stall_at) begin
                stalled = 1'b1;
                stall_seq();
            end
        end
        check("frame_sent", tx_log.size(), frame_len);
        // Last SEND -> TX_HOLD -> WAIT_RESP
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int i = 0; i < n_rep; i++) begin
            rx_byte = rep[i];
            rx_valid = 1'b1;
            last_rx_cyc = cyc;
            @(posedge clk);
            #1 rx_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
            end
        end
        for (int t = 0; t < 300 && pending; t++) @(negedge clk);
        check("resp_seen", pending ? 0 : 1, 1);
        pending = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        #3 check_reset_vals("por");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Write with ACK
        rep[0] = 8'h06;
        n_rep = 1;
        n0 = resp_cnt;
        run_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 2);
        check("wr_resp_count", resp_cnt - n0, 1);
        check("wr_err_lit", resp_error, 2'b00);
`ifndef SERIAL_CMD_CHECKSUM_EN
        lit = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        check("wr_len_lit", tx_log.size(), 9);
        for (int i = 0; i < 9 && i < tx_log.size(); i++) check("wr_stream_lit", tx_log[i], lit[i]);
`endif

        // Read 0x4 -> 0x12345678
        rep[0] = 8'h12; rep[1] = 8'h34; rep[2] = 8'h56; rep[3] = 8'h78;
        n_rep = 4;
`ifdef SERIAL_CMD_CHECKSUM_EN
        rep[4] = rep[0] + rep[1] + rep[2] + rep[3];
        n_rep = 5;
`endif
        run_txn(1'b0, 32'h0000_0004, 32'h0, 0, 0, -1);
        check("rd_rdata_lit", resp_rdata, 32'h1234_5678);
        check("rd_err_lit", resp_error, 2'b00);
`ifndef SERIAL_CMD_CHECKSUM_EN
        lit = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
        check("rd_len_lit", tx_log.size(), 5);
        for (int i = 0; i < 5 && i < tx_log.size(); i++) check("rd_stream_lit", tx_log[i], lit[i]);
`endif

        // Write with bad ACK byte
        rep[0] = 8'h15;
        n_rep = 1;
        run_txn(1'b1, 32'h0000_0020, 32'h0000_0001, 0, 0, 2);
        check("badack_err_lit", resp_error, 2'b10);
        check("badack_idle_ready", req_ready, 1);
        check("badack_rdata_held", resp_rdata, 32'h1234_5678);

        // Stray byte while idle, then read that times out after 2 bytes
        rx_byte = 8'h99;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
        rep[0] = 8'hAA; rep[1] = 8'hBB;
        n_rep = 2;
        run_txn(1'b0, 32'h0000_0100, 32'h0, 0, 0, TOUT);
        check("tout_err_lit", resp_error, 2'b01);
        check("tout_rdata_lit", resp_rdata, 32'h0000_AABB);

        // Transmitter stall mid-frame with a byte injected during SEND
        rep[0] = 8'h06;
        n_rep = 1;
        run_txn(1'b1, 32'h0000_0030, 32'h0BAD_F00D, 0, 3, 2);
        check("stall_err_lit", resp_error, 2'b00);

        // Read with gaps between reply bytes
        rep[0] = 8'hCA; rep[1] = 8'hFE; rep[2] = 8'h00; rep[3] = 8'h01;
        n_rep = 4;
`ifdef SERIAL_CMD_CHECKSUM_EN
        rep[4] = rep[0] + rep[1] + rep[2] + rep[3];
        n_rep = 5;
`endif
        run_txn(1'b0, 32'hFFFF_FFFC, 32'h0, 5, 0, -1);
        check("gap_rdata_lit", resp_rdata, 32'hCAFE_0001);

`ifdef SERIAL_CMD_CHECKSUM_EN
        // Data sum 01+02+03+04 = 0A
        rep[0] = 8'h01; rep[1] = 8'h02; rep[2] = 8'h03; rep[3] = 8'h04; rep[4] = 8'h0A;
        n_rep = 5;
        run_txn(1'b0, 32'h0000_0001, 32'h0, 0, 0, -1);
        lit = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h01, 8'h53, 8'h00, 8'h00, 8'h00};
        check("ck_len_lit", tx_log.size(), 6);
        for (int i = 0; i < 6 && i < tx_log.size(); i++) check("ck_stream_lit", tx_log[i], lit[i]);
        check("ck_ok_err_lit", resp_error, 2'b00);
        rep[4] = 8'h0C;
        run_txn(1'b0, 32'h0000_0001, 32'h0, 0, 0, -1);
        check("ck_bad_err_lit", resp_error, 2'b11);
        check("ck_bad_rdata_lit", resp_rdata, 32'h0102_0304);
`endif

        // Reset in the middle of a write frame abandons it silently
        build_frame(1'b1, 32'h0000_0040, 32'h1122_3344);
        pending = 1'b0;
        issue_req(1'b1, 32'h0000_0040, 32'h1122_3344);
        for (int t = 0; t < 100 && tx_log.size() < 2; t++) @(negedge clk);
        check("mid_partial_sent", tx_log.size(), 2);
        #1 rst_n = 1'b0;
        #1 check_reset_vals("midrst");
        exp_tx.delete();
        last_rdata = 32'h0;
        n0 = resp_cnt;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (TOUT + 10) @(posedge clk);
        #1 check("mid_no_resp", resp_cnt - n0, 0);

        // Recovery read after reset
        rep[0] = 8'h00; rep[1] = 8'h00; rep[2] = 8'h00; rep[3] = 8'h2A;
        n_rep = 4;
`ifdef SERIAL_CMD_CHECKSUM_EN
        rep[4] = 8'h2A;
        n_rep = 5;
`endif
        run_txn(1'b0, 32'h0000_0008, 32'h0, 0, 0, -1);
        check("recover_rdata_lit", resp_rdata, 32'h0000_002A);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
